// File: rtl/stack_spill_ctrl_pkg.sv
// Shared stack-op encodings and controller state for the stack spill/fill sequencer.
package stack_spill_ctrl_pkg;

    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_PUSH  = 3'd1,
        OP_BINOP = 3'd2,
        OP_POP   = 3'd3,
        OP_POP2  = 3'd4,
        OP_SWAP  = 3'd5
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/stack_spill_ctrl_op_decode.sv
// Combinational stackOP decode: minimum on-chip entries needed and net entry change.
// Zero latency; codes 6 and 7 decode as no-op.
module stack_spill_ctrl_op_decode
    import stack_spill_ctrl_pkg::*;
(
    input  logic [2:0] stack_op,
    output logic [1:0] need,
    output logic [2:0] delta
);

    always_comb begin
        need  = 2'd0;
        delta = 3'd0;
        case (stack_op)
            OP_PUSH:  begin need = 2'd0; delta = 3'b001; end
            OP_BINOP: begin need = 2'd2; delta = 3'b111; end
            OP_POP:   begin need = 2'd1; delta = 3'b111; end
            OP_POP2:  begin need = 2'd2; delta = 3'b110; end
            OP_SWAP:  begin need = 2'd2; delta = 3'b000; end
            default:  begin need = 2'd0; delta = 3'b000; end
        endcase
    end

endmodule

// File: rtl/stack_spill_ctrl.sv
// Spills the bottom stack entry to memory before an overflowing push and refills before an op short of entries.
// Commits in the same cycle when no memory traffic is needed; otherwise stalls commit until each transaction is acked.
module stack_spill_ctrl
    import stack_spill_ctrl_pkg::*;
#(
    parameter int               DEPTH      = DEPTH_DEF,
    parameter int               DATA_W     = 16,
    parameter int               ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] SPILL_BASE = 16'hF000,
    parameter int               SPILL_MAX  = 256
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [2:0]        stackOP,
    output logic              stall,
    input  logic [DATA_W-1:0] bottom_data,
    output logic              stk_drop_bot,
    output logic              stk_fill_bot,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SPL_W = $clog2(SPILL_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [SPL_W-1:0] SPILL_MAX_C = SPL_W'(SPILL_MAX);

    logic [1:0] need;
    logic [2:0] delta;

    stack_spill_ctrl_op_decode u_decode (
        .stack_op (stackOP),
        .need     (need),
        .delta    (delta)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SPL_W-1:0]  spilled_q, spilled_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic delta_pos, short_on_chip, need_spill, need_fill, need_unf;

    assign delta_pos     = ~delta[2] & (delta != 3'd0);
    assign short_on_chip = count_q < CNT_W'(need);
    assign need_spill    = inst_valid & delta_pos & (count_q == DEPTH_C);
    assign need_fill     = inst_valid & short_on_chip & (spilled_q != '0);
    // Short with nothing in memory is an underflow; it must stall too or count would wrap.
    assign need_unf      = inst_valid & short_on_chip & (spilled_q == '0);

    assign stall = need_spill | need_fill | need_unf | (state_q != ST_IDLE) | err_ovf_q | err_unf_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        spilled_d   = spilled_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        case (state_q)
            ST_IDLE: begin
                if (need_spill) begin
                    if (spilled_q == SPILL_MAX_C) begin
                        state_d   = ST_ERR;
                        err_ovf_d = 1'b1;
                    end else begin
                        state_d     = ST_SPILL;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = SPILL_BASE + ADDR_W'(spilled_q);
                        mem_wdata_d = bottom_data;
                    end
                end else if (need_fill) begin
                    state_d    = ST_FILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = SPILL_BASE + ADDR_W'(spilled_q) - ADDR_W'(1);
                end else if (need_unf) begin
                    state_d   = ST_ERR;
                    err_unf_d = 1'b1;
                end else if (inst_valid) begin
                    count_d = count_q + CNT_W'($signed(delta));
                end
            end
            ST_SPILL: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    count_d   = count_q - CNT_W'(1);
                    spilled_d = spilled_q + SPL_W'(1);
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    count_d   = count_q + CNT_W'(1);
                    spilled_d = spilled_q - SPL_W'(1);
                end
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            spilled_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            spilled_q   <= spilled_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    // Stack pulses coincide with the ack so the stack moves on the same edge as the counters.
    assign stk_drop_bot = (state_q == ST_SPILL) & mem_ack;
    assign stk_fill_bot = (state_q == ST_FILL) & mem_ack;
    assign fill_data    = stk_fill_bot ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_stack_spill_ctrl.sv
// Bench for stack_spill_ctrl: models the whole logical stack as one queue, with the deepest entries in memory.
module tb_stack_spill_ctrl;

    localparam int DEPTH     = 8;
    localparam int SPILL_MAX = 2;

    logic        CLK, reset, inst_valid;
    logic [2:0]  stackOP;
    logic        stall, stk_drop_bot, stk_fill_bot;
    logic [15:0] bottom_data, fill_data;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        err_ovf, err_unf;

    int checks = 0;
    int errors = 0;

    logic [15:0] lstk[$];
    int          ms;
    logic [15:0] smem [0:255];
    logic [15:0] last_addrs[$];
    int          ack_max = 2;

    stack_spill_ctrl #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(16),
                       .SPILL_BASE(16'hF000), .SPILL_MAX(SPILL_MAX)) dut (
        .CLK(CLK), .reset(reset), .inst_valid(inst_valid), .stackOP(stackOP),
        .stall(stall), .bottom_data(bottom_data), .stk_drop_bot(stk_drop_bot),
        .stk_fill_bot(stk_fill_bot), .fill_data(fill_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int op_need(input logic [2:0] op);
        case (op)
            3'd2, 3'd4, 3'd5: return 2;
            3'd3:             return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic int op_delta(input logic [2:0] op);
        case (op)
            3'd1:       return 1;
            3'd2, 3'd3: return -1;
            3'd4:       return -2;
            default:    return 0;
        endcase
    endfunction

    task automatic apply_op(input logic [2:0] op, input logic [15:0] val);
        logic [15:0] t;
        case (op)
            3'd1: lstk.push_back(val);
            3'd2: begin void'(lstk.pop_back()); void'(lstk.pop_back()); lstk.push_back(val); end
            3'd3: void'(lstk.pop_back());
            3'd4: begin void'(lstk.pop_back()); void'(lstk.pop_back()); end
            3'd5: begin
                t = lstk[lstk.size()-1];
                lstk[lstk.size()-1] = lstk[lstk.size()-2];
                lstk[lstk.size()-2] = t;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1; inst_valid = 1'b0; stackOP = 3'd0;
        mem_ack = 1'b0; mem_rdata = '0; bottom_data = '0;
        @(posedge CLK); @(posedge CLK); #1;
        reset = 1'b0;
        lstk.delete(); ms = 0;
    endtask

    // Presents one instruction, acts as stack datapath and memory, and checks every cycle until commit.
    task automatic run_op(input logic [2:0] op, input logic [15:0] val);
        int need, delta, sz, onchip, exp_sp, exp_fl, got_sp, got_fl, wait_c, delay;
        bit ovf_exp, unf_exp, committed, req_prev, we_exp;
        logic [15:0] a;
        need = op_need(op); delta = op_delta(op);
        sz = lstk.size(); onchip = sz - ms;
        exp_sp  = (delta > 0 && onchip == DEPTH) ? 1 : 0;
        ovf_exp = (exp_sp == 1) && (ms == SPILL_MAX);
        if (ovf_exp) exp_sp = 0;
        exp_fl  = (!ovf_exp && need > onchip) ? ((ms < need - onchip) ? ms : need - onchip) : 0;
        unf_exp = !ovf_exp && (sz < need);
        got_sp = 0; got_fl = 0; wait_c = 0; committed = 0; req_prev = 0;
        delay = $urandom_range(0, ack_max);
        last_addrs.delete();
        inst_valid = 1'b1; stackOP = op;
        for (int cyc = 0; cyc < 40 && !committed; cyc++) begin
            bottom_data = (ms < lstk.size()) ? lstk[ms] : 16'($urandom);
            mem_ack   = mem_req && (wait_c >= delay);
            mem_rdata = (mem_req && !mem_we) ? smem[mem_addr[7:0]] : 16'($urandom);
            #1;
            if (cyc == 0) begin
                checks++;
                if (stall !== (exp_sp > 0 || exp_fl > 0 || ovf_exp || unf_exp))
                    $display("FAIL first_stall op=%0d got %b exp %b", op, stall, (exp_sp > 0 || exp_fl > 0 || ovf_exp || unf_exp));
                if (stall !== (exp_sp > 0 || exp_fl > 0 || ovf_exp || unf_exp)) errors++;
            end
            if (mem_req) begin
                if (!req_prev) begin
                    we_exp = (got_sp < exp_sp);
                    a = we_exp ? 16'hF000 + 16'(ms) : 16'hF000 + 16'(ms) - 16'd1;
                    checks++;
                    if (mem_we !== we_exp || mem_addr !== a) begin
                        errors++;
                        $display("FAIL mem_request got we=%b addr=%h exp we=%b addr=%h", mem_we, mem_addr, we_exp, a);
                    end
                    if (we_exp && ms < lstk.size()) begin
                        checks++;
                        if (mem_wdata !== lstk[ms]) begin
                            errors++;
                            $display("FAIL spill_wdata got %h exp %h", mem_wdata, lstk[ms]);
                        end
                    end
                    last_addrs.push_back(mem_addr);
                end else begin
                    checks++;
                    if (mem_addr !== last_addrs[last_addrs.size()-1]) begin
                        errors++;
                        $display("FAIL addr_hold got %h exp %h", mem_addr, last_addrs[last_addrs.size()-1]);
                    end
                end
                if (mem_ack) begin
                    checks++;
                    if (mem_we) begin
                        if (stk_drop_bot !== 1'b1 || stk_fill_bot !== 1'b0 || ms >= lstk.size()) begin
                            errors++;
                            $display("FAIL spill_ack got drop=%b fill=%b exp drop=1 fill=0", stk_drop_bot, stk_fill_bot);
                        end else begin
                            smem[mem_addr[7:0]] = mem_wdata; ms++; got_sp++;
                        end
                    end else begin
                        if (ms == 0 || stk_fill_bot !== 1'b1 || stk_drop_bot !== 1'b0) begin
                            errors++;
                            $display("FAIL fill_ack got fill=%b drop=%b spilled=%0d exp fill=1 drop=0", stk_fill_bot, stk_drop_bot, ms);
                        end else begin
                            if (fill_data !== lstk[ms-1]) begin
                                errors++;
                                $display("FAIL fill_data got %h exp %h", fill_data, lstk[ms-1]);
                            end
                            ms--; got_fl++;
                        end
                    end
                    wait_c = 0; req_prev = 0; delay = $urandom_range(0, ack_max);
                end else begin
                    wait_c++; req_prev = 1;
                end
            end else begin
                checks++;
                if (stk_drop_bot !== 1'b0 || stk_fill_bot !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_pulse got drop=%b fill=%b exp 0 0", stk_drop_bot, stk_fill_bot);
                end
            end
            if (!stall) begin
                apply_op(op, val);
                committed = 1;
            end
            @(posedge CLK); #1;
        end
        inst_valid = 1'b0; stackOP = 3'd0; mem_ack = 1'b0;
        #1;
        if (ovf_exp || unf_exp) begin
            checks++;
            if (committed || stall !== 1'b1) begin
                errors++;
                $display("FAIL err_hold got committed=%0d stall=%b exp 0 1", committed, stall);
            end
            checks++;
            if ((ovf_exp && err_ovf !== 1'b1) || (unf_exp && err_unf !== 1'b1)) begin
                errors++;
                $display("FAIL err_flag got ovf=%b unf=%b exp ovf=%0d unf=%0d", err_ovf, err_unf, ovf_exp, unf_exp);
            end
            checks++;
            if (got_sp != 0 || got_fl != exp_fl || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL err_traffic got sp=%0d fl=%0d req=%b exp 0 %0d 0", got_sp, got_fl, mem_req, exp_fl);
            end
        end else begin
            checks++;
            if (!committed || got_sp != exp_sp || got_fl != exp_fl) begin
                errors++;
                $display("FAIL commit op=%0d got commit=%0d sp=%0d fl=%0d exp 1 %0d %0d", op, committed, got_sp, got_fl, exp_sp, exp_fl);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inst_valid = 1'b0; stackOP = 3'd0;
        mem_ack = 1'b0; mem_rdata = 16'h1234; bottom_data = 16'h5678;
        #3;
        checks++;
        if ({stall, stk_drop_bot, stk_fill_bot, mem_req, mem_we, err_ovf, err_unf} !== 7'b0 ||
            fill_data !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b req=%b we=%b addr=%h wdata=%h fill=%h ovf=%b unf=%b exp all 0",
                     stall, mem_req, mem_we, mem_addr, mem_wdata, fill_data, err_ovf, err_unf);
        end
        do_reset();
    endtask

    task automatic test_spill();
        do_reset();
        for (int i = 0; i < 8; i++) run_op(3'd1, (i == 0) ? 16'hBEEF : 16'(i));
        run_op(3'd1, 16'h0009);
        checks++;
        if (last_addrs.size() != 1 || last_addrs[0] !== 16'hF000 || smem[0] !== 16'hBEEF ||
            ms != 1 || lstk.size() - ms != 8) begin
            errors++;
            $display("FAIL spill_9th got reqs=%0d spilled=%0d mem0=%h exp 1 1 beef", last_addrs.size(), ms, smem[0]);
        end
    endtask

    task automatic test_fill();
        run_op(3'd1, 16'h000A);
        for (int i = 0; i < 8; i++) run_op(3'd3, 16'h0);
        run_op(3'd4, 16'h0);
        checks++;
        if (last_addrs.size() != 2 || last_addrs[0] !== 16'hF001 || last_addrs[1] !== 16'hF000 ||
            ms != 0 || lstk.size() != 0) begin
            errors++;
            $display("FAIL pop2_fills got reqs=%0d spilled=%0d size=%0d exp 2 fills F001,F000 0 0", last_addrs.size(), ms, lstk.size());
        end
    endtask

    task automatic test_swap();
        for (int i = 0; i < 9; i++) run_op(3'd1, 16'h0100 + 16'(i));
        for (int i = 0; i < 7; i++) run_op(3'd3, 16'h0);
        run_op(3'd5, 16'h0);
        checks++;
        if (last_addrs.size() != 1 || last_addrs[0] !== 16'hF000 || lstk.size() - ms != 2 ||
            lstk[1] !== 16'h0100 || lstk[0] !== 16'h0101) begin
            errors++;
            $display("FAIL swap_fill got reqs=%0d onchip=%0d top=%h exp 1 2 0100", last_addrs.size(), lstk.size() - ms, lstk[1]);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        run_op(3'd3, 16'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall !== 1'b1 || mem_req !== 1'b0 || err_unf !== 1'b1 || err_ovf !== 1'b0) begin
                errors++;
                $display("FAIL unf_sticky got stall=%b req=%b unf=%b ovf=%b exp 1 0 1 0", stall, mem_req, err_unf, err_ovf);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) run_op(3'd1, 16'h0200 + 16'(i));
        run_op(3'd1, 16'h0EEE);
        checks++;
        if (ms != SPILL_MAX || err_unf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_state got spilled=%0d unf=%b exp %0d 0", ms, err_unf, SPILL_MAX);
        end
    endtask

    task automatic test_reset_mid_spill();
        bit seen;
        do_reset();
        for (int i = 0; i < 8; i++) run_op(3'd1, 16'h0300 + 16'(i));
        inst_valid = 1'b1; stackOP = 3'd1; bottom_data = lstk[0]; mem_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            #1;
            if (mem_req === 1'b1) seen = 1;
            else begin @(posedge CLK); #1; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_spill_req got req=%b exp 1", mem_req); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stk_drop_bot !== 1'b0 || stk_fill_bot !== 1'b0 || stall !== 1'b0 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got req=%b drop=%b stall=%b addr=%h wdata=%h exp 0 0 0 0000 0000",
                     mem_req, stk_drop_bot, stall, mem_addr, mem_wdata);
        end
        inst_valid = 1'b0; stackOP = 3'd0;
        @(posedge CLK); #1;
        reset = 1'b0;
        lstk.delete(); ms = 0;
        for (int i = 0; i < 9; i++) run_op(3'd1, 16'h0400 + 16'(i));
        checks++;
        if (last_addrs.size() != 1 || last_addrs[0] !== 16'hF000 || ms != 1) begin
            errors++;
            $display("FAIL post_reset_spill got reqs=%0d spilled=%0d exp 1 at F000", last_addrs.size(), ms);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int sz;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            sz = lstk.size();
            op = 3'($urandom_range(0, 7));
            if (op == 3'd1 && sz >= DEPTH + SPILL_MAX) op = 3'd3;
            if ((op == 3'd2 || op == 3'd4 || op == 3'd5) && sz < 2) op = 3'd1;
            if (op == 3'd3 && sz < 1) op = 3'd1;
            if (sz < 4 && $urandom_range(0, 2) == 0) op = 3'd1;
            run_op(op, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                inst_valid = 1'b0;
                #1;
                checks++;
                if (stall !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_quiet got stall=%b req=%b exp 0 0", stall, mem_req);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = '0;
        ms = 0;
        test_reset();
        test_spill();
        test_fill();
        test_swap();
        test_underflow();
        test_overflow();
        test_reset_mid_spill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
